// File: rtl/video_timing_gen_if.sv
// rtl/video_timing_gen_if.sv - run/config request and video timing bus for video_timing_gen
// Line-interrupt signals exist only when VTG_LINE_IRQ_EN is defined.
interface video_timing_gen_if #(
   parameter int CNT_W = 12
);
   logic             en;
   logic             cfg_update;
   logic [CNT_W-1:0] cfg_h_active;
   logic [CNT_W-1:0] cfg_h_fp;
   logic [CNT_W-1:0] cfg_h_sync;
   logic [CNT_W-1:0] cfg_h_bp;
   logic [CNT_W-1:0] cfg_v_active;
   logic [CNT_W-1:0] cfg_v_fp;
   logic [CNT_W-1:0] cfg_v_sync;
   logic [CNT_W-1:0] cfg_v_bp;
   logic             cfg_hs_pol;
   logic             cfg_vs_pol;
   logic             cfg_busy;
   logic             cfg_err;
   logic             hs;
   logic             vs;
   logic             de;
   logic             fs;
   logic [CNT_W-1:0] active_x;
   logic [CNT_W-1:0] active_y;
`ifdef VTG_LINE_IRQ_EN
   logic [CNT_W-1:0] cfg_irq_line;
   logic             line_irq;
`endif

   modport master (
`ifdef VTG_LINE_IRQ_EN
      output cfg_irq_line,
      input  line_irq,
`endif
      output en, cfg_update,
      output cfg_h_active, cfg_h_fp, cfg_h_sync, cfg_h_bp,
      output cfg_v_active, cfg_v_fp, cfg_v_sync, cfg_v_bp,
      output cfg_hs_pol, cfg_vs_pol,
      input  cfg_busy, cfg_err, hs, vs, de, fs, active_x, active_y
   );

   modport slave (
`ifdef VTG_LINE_IRQ_EN
      input  cfg_irq_line,
      output line_irq,
`endif
      input  en, cfg_update,
      input  cfg_h_active, cfg_h_fp, cfg_h_sync, cfg_h_bp,
      input  cfg_v_active, cfg_v_fp, cfg_v_sync, cfg_v_bp,
      input  cfg_hs_pol, cfg_vs_pol,
      output cfg_busy, cfg_err, hs, vs, de, fs, active_x, active_y
   );
endinterface

// File: rtl/video_timing_gen.sv
// rtl/video_timing_gen.sv - video timing generator with staged, frame-aligned reconfiguration
// Define VTG_LINE_IRQ_EN to add the per-line interrupt (cfg_irq_line / line_irq).
module video_timing_gen #(
   parameter int CNT_W        = 12,
   parameter int H_ACTIVE_DEF = 800,
   parameter int H_FP_DEF     = 40,
   parameter int H_SYNC_DEF   = 128,
   parameter int H_BP_DEF     = 88,
   parameter int V_ACTIVE_DEF = 480,
   parameter int V_FP_DEF     = 1,
   parameter int V_SYNC_DEF   = 3,
   parameter int V_BP_DEF     = 21,
   parameter bit HS_POL_DEF   = 1'b0,
   parameter bit VS_POL_DEF   = 1'b0
) (
   input  logic              clk,
   input  logic              rst_n,
   video_timing_gen_if.slave bus
);
   // Totals and window edges need two extra bits so four CNT_W fields never overflow.
   localparam int TW = CNT_W + 2;

   typedef struct packed {
      logic [CNT_W-1:0] h_act;
      logic [CNT_W-1:0] h_fp;
      logic [CNT_W-1:0] h_sync;
      logic [CNT_W-1:0] h_bp;
      logic [CNT_W-1:0] v_act;
      logic [CNT_W-1:0] v_fp;
      logic [CNT_W-1:0] v_sync;
      logic [CNT_W-1:0] v_bp;
      logic             hs_pol;
      logic             vs_pol;
   } timing_t;

   localparam timing_t DEF_TIMING = '{
      h_act:  CNT_W'(H_ACTIVE_DEF),
      h_fp:   CNT_W'(H_FP_DEF),
      h_sync: CNT_W'(H_SYNC_DEF),
      h_bp:   CNT_W'(H_BP_DEF),
      v_act:  CNT_W'(V_ACTIVE_DEF),
      v_fp:   CNT_W'(V_FP_DEF),
      v_sync: CNT_W'(V_SYNC_DEF),
      v_bp:   CNT_W'(V_BP_DEF),
      hs_pol: HS_POL_DEF,
      vs_pol: VS_POL_DEF
   };

   timing_t          live;
   timing_t          staged;
   timing_t          req;
   logic             busy;
   logic             req_ok;
   logic             h_last;
   logic             v_last;
   logic             wrap;
   logic             apply;
   logic [TW-1:0]    h_cnt;
   logic [TW-1:0]    v_cnt;
   logic [TW-1:0]    h_total;
   logic [TW-1:0]    v_total;
   logic [TW-1:0]    hs_start;
   logic [TW-1:0]    hs_stop;
   logic [TW-1:0]    vs_start;
   logic [TW-1:0]    vs_stop;
   logic             de_d;
   logic             fs_d;
   logic             hs_d;
   logic             vs_d;
   logic [CNT_W-1:0] x_d;
   logic [CNT_W-1:0] y_d;

   always_comb begin
      req = '{
         h_act:  bus.cfg_h_active,
         h_fp:   bus.cfg_h_fp,
         h_sync: bus.cfg_h_sync,
         h_bp:   bus.cfg_h_bp,
         v_act:  bus.cfg_v_active,
         v_fp:   bus.cfg_v_fp,
         v_sync: bus.cfg_v_sync,
         v_bp:   bus.cfg_v_bp,
         hs_pol: bus.cfg_hs_pol,
         vs_pol: bus.cfg_vs_pol
      };
   end

   assign req_ok = (req.h_act  != '0) && (req.h_fp  != '0) &&
                   (req.h_sync != '0) && (req.h_bp  != '0) &&
                   (req.v_act  != '0) && (req.v_fp  != '0) &&
                   (req.v_sync != '0) && (req.v_bp  != '0);

   assign h_total  = TW'(live.h_act) + TW'(live.h_fp) + TW'(live.h_sync) + TW'(live.h_bp);
   assign v_total  = TW'(live.v_act) + TW'(live.v_fp) + TW'(live.v_sync) + TW'(live.v_bp);
   assign hs_start = TW'(live.h_act) + TW'(live.h_fp);
   assign hs_stop  = hs_start + TW'(live.h_sync);
   assign vs_start = TW'(live.v_act) + TW'(live.v_fp);
   assign vs_stop  = vs_start + TW'(live.v_sync);

   assign h_last = (h_cnt >= h_total - TW'(1));
   assign v_last = (v_cnt >= v_total - TW'(1));
   assign wrap   = bus.en & h_last & v_last;
   // While stopped the counters sit at (0,0), so a pending set can go live at once.
   assign apply  = busy & (~bus.en | wrap);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         live   <= DEF_TIMING;
         staged <= '0;
         busy   <= 1'b0;
         h_cnt  <= '0;
         v_cnt  <= '0;
      end else begin
         if (apply) begin
            live <= staged;
            busy <= 1'b0;
         end
         if (bus.cfg_update && req_ok) begin
            staged <= req;
            busy   <= 1'b1;
         end
         if (!bus.en) begin
            h_cnt <= '0;
            v_cnt <= '0;
         end else if (h_last) begin
            h_cnt <= '0;
            v_cnt <= v_last ? '0 : v_cnt + TW'(1);
         end else begin
            h_cnt <= h_cnt + TW'(1);
         end
      end
   end

   assign bus.cfg_busy = busy;

   always_comb begin
      de_d = 1'b0;
      fs_d = 1'b0;
      hs_d = ~live.hs_pol;
      vs_d = ~live.vs_pol;
      x_d  = '0;
      y_d  = '0;
      if (bus.en) begin
         de_d = (h_cnt < TW'(live.h_act)) && (v_cnt < TW'(live.v_act));
         fs_d = (h_cnt == '0) && (v_cnt == '0);
         if ((h_cnt >= hs_start) && (h_cnt < hs_stop)) hs_d = live.hs_pol;
         if ((v_cnt >= vs_start) && (v_cnt < vs_stop)) vs_d = live.vs_pol;
         if (de_d) begin
            x_d = h_cnt[CNT_W-1:0];
            y_d = v_cnt[CNT_W-1:0];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         bus.hs       <= ~HS_POL_DEF;
         bus.vs       <= ~VS_POL_DEF;
         bus.de       <= 1'b0;
         bus.fs       <= 1'b0;
         bus.active_x <= '0;
         bus.active_y <= '0;
         bus.cfg_err  <= 1'b0;
      end else begin
         bus.hs       <= hs_d;
         bus.vs       <= vs_d;
         bus.de       <= de_d;
         bus.fs       <= fs_d;
         bus.active_x <= x_d;
         bus.active_y <= y_d;
         bus.cfg_err  <= bus.cfg_update & ~req_ok;
      end
   end

`ifdef VTG_LINE_IRQ_EN
   logic irq_d;

   // Lines at or beyond V_TOTAL are never reached, so no extra range check is needed.
   assign irq_d = bus.en && (h_cnt == '0) && (v_cnt == TW'(bus.cfg_irq_line));

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         bus.line_irq <= 1'b0;
      end else begin
         bus.line_irq <= irq_d;
      end
   end
`endif

endmodule

// File: tb/tb_video_timing_gen.sv
// tb/tb_video_timing_gen.sv - randomized self-checking bench for video_timing_gen
// The reference model tracks a linear position within the frame and derives h/v by division.
module tb_video_timing_gen;
   localparam int CNT_W = 12;
   localparam int H_DEF_TOTAL = 1056;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   video_timing_gen_if #(.CNT_W(CNT_W)) vif ();

   video_timing_gen #(.CNT_W(CNT_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (vif)
   );

   typedef struct {
      int ha, hf, hsn, hb, va, vf, vsn, vb;
      bit hp, vp;
   } tcfg_t;

   tcfg_t       m_live;
   tcfg_t       m_staged;
   tcfg_t       req;
   bit          m_busy;
   int          m_pos;
   int          irq_line;
   logic [31:0] exp_vec;
   int          errors = 0;
   int          checks = 0;
   int          cyc = 0;

   function automatic tcfg_t mk_cfg(input int ha, hf, hsn, hb, va, vf, vsn, vb, input bit hp, vp);
      tcfg_t c;
      c.ha = ha; c.hf = hf; c.hsn = hsn; c.hb = hb;
      c.va = va; c.vf = vf; c.vsn = vsn; c.vb = vb;
      c.hp = hp; c.vp = vp;
      return c;
   endfunction

   function automatic tcfg_t def_cfg();
      return mk_cfg(800, 40, 128, 88, 480, 1, 3, 21, 1'b0, 1'b0);
   endfunction

   function automatic bit cfg_ok(input tcfg_t c);
      return c.ha > 0 && c.hf > 0 && c.hsn > 0 && c.hb > 0 &&
             c.va > 0 && c.vf > 0 && c.vsn > 0 && c.vb > 0;
   endfunction

   function automatic int r4();
      return int'($urandom_range(4, 1));
   endfunction

   function automatic tcfg_t rand_cfg(input bit allow_zero);
      tcfg_t c;
      c = mk_cfg(r4(), r4(), r4(), r4(), r4(), r4(), r4(), r4(),
                 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)));
      if (allow_zero && $urandom_range(3, 0) == 0) begin
         case ($urandom_range(7, 0))
            0: c.ha = 0;
            1: c.hf = 0;
            2: c.hsn = 0;
            3: c.hb = 0;
            4: c.va = 0;
            5: c.vf = 0;
            6: c.vsn = 0;
            default: c.vb = 0;
         endcase
      end
      return c;
   endfunction

   function automatic logic [31:0] obs_vec();
      logic irq;
      irq = 1'b0;
`ifdef VTG_LINE_IRQ_EN
      irq = vif.line_irq;
`endif
      return {1'b0, irq, vif.hs, vif.vs, vif.de, vif.fs, vif.cfg_busy, vif.cfg_err,
              vif.active_x, vif.active_y};
   endfunction

   // Computes the expected post-edge outputs from the model, advances the model, then clocks.
   task automatic tick();
      int ht, vt, h, v, x, y;
      bit de, fsx, hsx, vsx, irq, err, wrap, apply;
      vif.cfg_h_active = CNT_W'(req.ha);
      vif.cfg_h_fp     = CNT_W'(req.hf);
      vif.cfg_h_sync   = CNT_W'(req.hsn);
      vif.cfg_h_bp     = CNT_W'(req.hb);
      vif.cfg_v_active = CNT_W'(req.va);
      vif.cfg_v_fp     = CNT_W'(req.vf);
      vif.cfg_v_sync   = CNT_W'(req.vsn);
      vif.cfg_v_bp     = CNT_W'(req.vb);
      vif.cfg_hs_pol   = req.hp;
      vif.cfg_vs_pol   = req.vp;
`ifdef VTG_LINE_IRQ_EN
      vif.cfg_irq_line = CNT_W'(irq_line);
`endif
      if (!rst_n) begin
         m_live  = def_cfg();
         m_busy  = 1'b0;
         m_pos   = 0;
         exp_vec = {1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 24'd0};
      end else begin
         ht  = m_live.ha + m_live.hf + m_live.hsn + m_live.hb;
         vt  = m_live.va + m_live.vf + m_live.vsn + m_live.vb;
         h   = m_pos % ht;
         v   = m_pos / ht;
         de  = vif.en && h < m_live.ha && v < m_live.va;
         fsx = vif.en && m_pos == 0;
         hsx = (vif.en && h >= m_live.ha + m_live.hf && h < m_live.ha + m_live.hf + m_live.hsn)
               ? m_live.hp : !m_live.hp;
         vsx = (vif.en && v >= m_live.va + m_live.vf && v < m_live.va + m_live.vf + m_live.vsn)
               ? m_live.vp : !m_live.vp;
         irq = 1'b0;
`ifdef VTG_LINE_IRQ_EN
         irq = vif.en && h == 0 && v == irq_line;
`endif
         err   = vif.cfg_update && !cfg_ok(req);
         x     = de ? h : 0;
         y     = de ? v : 0;
         wrap  = vif.en && (m_pos == ht * vt - 1);
         apply = m_busy && (!vif.en || wrap);
         if (apply) begin
            m_live = m_staged;
            m_busy = 1'b0;
         end
         if (vif.cfg_update && !err) begin
            m_staged = req;
            m_busy   = 1'b1;
         end
         m_pos   = (vif.en && !wrap) ? m_pos + 1 : 0;
         exp_vec = {1'b0, irq, hsx, vsx, de, fsx, m_busy, err, CNT_W'(x), CNT_W'(y)};
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      vif.en = 1'b0;
      vif.cfg_update = 1'b0;
      req = def_cfg();
      irq_line = 0;
      for (int i = 0; i < 4; i++) begin
         tick();
         checks++;
         if (obs_vec() !== exp_vec) begin
            errors++;
            $display("FAIL reset_model cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec);
         end
      end
      checks++;
      if (vif.hs !== 1'b1 || vif.vs !== 1'b1) begin
         errors++;
         $display("FAIL reset_sync hs/vs got=%b%b exp=11", vif.hs, vif.vs);
      end
      checks++;
      if ({vif.de, vif.fs, vif.cfg_busy, vif.cfg_err} !== 4'b0000) begin
         errors++;
         $display("FAIL reset_flags de/fs/busy/err got=%b exp=0000",
                  {vif.de, vif.fs, vif.cfg_busy, vif.cfg_err});
      end
      checks++;
      if (vif.active_x !== '0 || vif.active_y !== '0) begin
         errors++;
         $display("FAIL reset_xy got=%0d,%0d exp=0,0", vif.active_x, vif.active_y);
      end
   endtask

   task automatic test_default_lines();
      int de_rise = -1, hs_fall = -1, hs_rise = -1, de_cnt0 = 0;
      logic prev_de = 1'b0, prev_hs = 1'b1;
      rst_n = 1'b1;
      vif.en = 1'b1;
      for (int i = 0; i < 3 * H_DEF_TOTAL; i++) begin
         tick();
         checks++;
         if (obs_vec() !== exp_vec) begin
            errors++;
            $display("FAIL default_model cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec);
         end
         if (i == 0) begin
            checks++;
            if (vif.fs !== 1'b1) begin
               errors++;
               $display("FAIL default_first_fs got=%b exp=1", vif.fs);
            end
         end
         if (i < H_DEF_TOTAL && vif.de === 1'b1) de_cnt0++;
         if (vif.de === 1'b1 && prev_de === 1'b0 && de_rise < 0) de_rise = i;
         if (vif.hs === 1'b0 && prev_hs === 1'b1 && hs_fall < 0) hs_fall = i;
         if (vif.hs === 1'b1 && prev_hs === 1'b0 && hs_fall >= 0 && hs_rise < 0) hs_rise = i;
         prev_de = vif.de;
         prev_hs = vif.hs;
      end
      checks++;
      if (de_cnt0 != 800) begin
         errors++;
         $display("FAIL default_de_width got=%0d exp=800", de_cnt0);
      end
      checks++;
      if (hs_fall - de_rise != 840) begin
         errors++;
         $display("FAIL default_hs_offset got=%0d exp=840", hs_fall - de_rise);
      end
      checks++;
      if (hs_rise - hs_fall != 128) begin
         errors++;
         $display("FAIL default_hs_width got=%0d exp=128", hs_rise - hs_fall);
      end
   endtask

   task automatic test_cfg_err();
      req = def_cfg();
      req.vsn = 0;
      vif.cfg_update = 1'b1;
      tick();
      vif.cfg_update = 1'b0;
      checks++;
      if (obs_vec() !== exp_vec) begin
         errors++;
         $display("FAIL cfg_err_model cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec);
      end
      checks++;
      if (vif.cfg_err !== 1'b1 || vif.cfg_busy !== 1'b0) begin
         errors++;
         $display("FAIL cfg_err_pulse err/busy got=%b%b exp=10", vif.cfg_err, vif.cfg_busy);
      end
      tick();
      checks++;
      if (vif.cfg_err !== 1'b0) begin
         errors++;
         $display("FAIL cfg_err_clear got=%b exp=0", vif.cfg_err);
      end
      req = rand_cfg(1'b0);
      vif.cfg_update = 1'b1;
      tick();
      req.ha = 0;
      tick();
      vif.cfg_update = 1'b0;
      checks++;
      if (vif.cfg_busy !== 1'b1 || vif.cfg_err !== 1'b1) begin
         errors++;
         $display("FAIL cfg_err_while_busy busy/err got=%b%b exp=11", vif.cfg_busy, vif.cfg_err);
      end
      for (int i = 0; i < 20; i++) begin
         tick();
         checks++;
         if (obs_vec() !== exp_vec) begin
            errors++;
            $display("FAIL cfg_err_after cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec);
         end
      end
   endtask

   task automatic test_small_cfg();
      int busy_fall = -1, fs_at = -1, de_c, hs_c, vs_c, fs_extra = 0;
      vif.en = 1'b0;
      tick();
      vif.en = 1'b1;
      for (int i = 0; i < 10; i++) tick();
      req = mk_cfg(4, 1, 2, 1, 3, 1, 1, 1, 1'b1, 1'b1);
      vif.cfg_update = 1'b1;
      tick();
      vif.cfg_update = 1'b0;
      checks++;
      if (vif.cfg_busy !== 1'b1) begin
         errors++;
         $display("FAIL small_busy_set got=%b exp=1", vif.cfg_busy);
      end
      for (int i = 0; i < 2000 && fs_at < 0; i++) begin
         tick();
         checks++;
         if (obs_vec() !== exp_vec) begin
            errors++;
            $display("FAIL small_wait_model cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec);
         end
         if (vif.cfg_busy === 1'b0 && busy_fall < 0) busy_fall = cyc;
         if (vif.fs === 1'b1) fs_at = cyc;
      end
      checks++;
      if (fs_at < 0 || fs_at - busy_fall != 1) begin
         errors++;
         $display("FAIL small_apply_at_wrap fs_cyc=%0d busy_fall_cyc=%0d exp_gap=1", fs_at, busy_fall);
      end
      de_c = int'(vif.de);
      hs_c = int'(vif.hs);
      vs_c = int'(vif.vs);
      for (int i = 1; i <= 48; i++) begin
         tick();
         checks++;
         if (obs_vec() !== exp_vec) begin
            errors++;
            $display("FAIL small_frame_model cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec);
         end
         if (i < 48) begin
            de_c += int'(vif.de === 1'b1);
            hs_c += int'(vif.hs === 1'b1);
            vs_c += int'(vif.vs === 1'b1);
            fs_extra += int'(vif.fs === 1'b1);
         end
      end
      checks++;
      if (vif.fs !== 1'b1 || fs_extra != 0) begin
         errors++;
         $display("FAIL small_fs_period fs@48=%b extra=%0d exp 1 and 0", vif.fs, fs_extra);
      end
      checks++;
      if (de_c != 12 || hs_c != 12 || vs_c != 8) begin
         errors++;
         $display("FAIL small_counts de/hs/vs got=%0d/%0d/%0d exp=12/12/8", de_c, hs_c, vs_c);
      end
   endtask

   task automatic test_wrap_update();
      int fs_t[3];
      int nfs = 0;
      for (int i = 0; i < 200 && m_pos != 47; i++) tick();
      req = mk_cfg(5, 2, 1, 1, 2, 1, 1, 1, 1'b0, 1'b1);
      vif.cfg_update = 1'b1;
      tick();
      vif.cfg_update = 1'b0;
      for (int i = 0; i < 300 && nfs < 3; i++) begin
         tick();
         checks++;
         if (obs_vec() !== exp_vec) begin
            errors++;
            $display("FAIL wrap_model cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec);
         end
         if (vif.fs === 1'b1) begin
            if (nfs == 0) begin
               checks++;
               if (vif.cfg_busy !== 1'b1) begin
                  errors++;
                  $display("FAIL wrap_still_busy got=%b exp=1", vif.cfg_busy);
               end
            end
            fs_t[nfs] = cyc;
            nfs++;
         end
      end
      checks++;
      if (nfs != 3 || fs_t[1] - fs_t[0] != 48 || fs_t[2] - fs_t[1] != 45) begin
         errors++;
         $display("FAIL wrap_periods nfs=%0d p1=%0d p2=%0d exp 3/48/45",
                  nfs, fs_t[1] - fs_t[0], fs_t[2] - fs_t[1]);
      end
   endtask

   task automatic test_random();
      int n, upd_at, off_at;
      for (int it = 0; it < 25; it++) begin
         req      = rand_cfg(1'b1);
         irq_line = int'($urandom_range(12, 0));
         n        = int'($urandom_range(150, 30));
         upd_at   = int'($urandom_range(n - 1, 0));
         off_at   = ($urandom_range(1, 0) == 0) ? int'($urandom_range(n - 1, 0)) : n;
         for (int i = 0; i < n; i++) begin
            vif.cfg_update = (i == upd_at);
            vif.en = !(i >= off_at && i < off_at + 3);
            tick();
            checks++;
            if (obs_vec() !== exp_vec) begin
               errors++;
               $display("FAIL random_model it=%0d cyc=%0d got=%h exp=%h", it, cyc, obs_vec(), exp_vec);
            end
         end
      end
      vif.cfg_update = 1'b0;
      vif.en = 1'b1;
   endtask

   task automatic test_reset_mid();
      int de_cnt = 0, busy_seen = 0;
      req = def_cfg();
      vif.en = 1'b0;
      vif.cfg_update = 1'b1;
      tick();
      vif.cfg_update = 1'b0;
      tick();
      vif.en = 1'b1;
      for (int i = 0; i < 30; i++) tick();
      req = rand_cfg(1'b0);
      vif.cfg_update = 1'b1;
      tick();
      vif.cfg_update = 1'b0;
      for (int i = 0; i < 5; i++) tick();
      checks++;
      if (vif.cfg_busy !== 1'b1) begin
         errors++;
         $display("FAIL rstmid_busy_before got=%b exp=1", vif.cfg_busy);
      end
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      checks++;
      if ({vif.hs, vif.vs, vif.de, vif.fs, vif.cfg_busy} !== 5'b11000 || vif.active_x !== '0) begin
         errors++;
         $display("FAIL rstmid_outputs hs/vs/de/fs/busy got=%b exp=11000",
                  {vif.hs, vif.vs, vif.de, vif.fs, vif.cfg_busy});
      end
      for (int i = 0; i < H_DEF_TOTAL + 40; i++) begin
         tick();
         checks++;
         if (obs_vec() !== exp_vec) begin
            errors++;
            $display("FAIL rstmid_model cyc=%0d got=%h exp=%h", cyc, obs_vec(), exp_vec);
         end
         if (i < H_DEF_TOTAL && vif.de === 1'b1) de_cnt++;
         if (vif.cfg_busy !== 1'b0) busy_seen++;
      end
      checks++;
      if (de_cnt != 800 || busy_seen != 0) begin
         errors++;
         $display("FAIL rstmid_default_resume de=%0d busy_cycles=%0d exp 800/0", de_cnt, busy_seen);
      end
   endtask

   initial begin
      test_reset();
      test_default_lines();
      test_cfg_err();
      test_small_cfg();
      test_wrap_update();
      test_random();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/video_timing_gen.md
VIDEO_TIMING_GEN -- requirements
Module: video_timing_gen

Interface
REQ-001 Parameter CNT_W, 12, width of all timing counters, timing fields and pixel coordinates.
REQ-002 Parameter H_ACTIVE_DEF/H_FP_DEF/H_SYNC_DEF/H_BP_DEF, 800/40/128/88, horizontal timing loaded at reset.
REQ-003 Parameter V_ACTIVE_DEF/V_FP_DEF/V_SYNC_DEF/V_BP_DEF, 480/1/3/21, vertical timing loaded at reset.
REQ-004 Parameter HS_POL_DEF/VS_POL_DEF, 0/0, sync active level loaded at reset.
REQ-005 clk  input  1  pixel clock; single clock domain.
REQ-006 rst_n  input  1  reset, synchronous to clk, active-low.
REQ-007 en  input  1  timing run enable.
REQ-008 cfg_update  input  1  one-cycle request to stage the cfg_* inputs.
REQ-009 cfg_h_active, cfg_h_fp, cfg_h_sync, cfg_h_bp  input  CNT_W each  requested horizontal timing.
REQ-010 cfg_v_active, cfg_v_fp, cfg_v_sync, cfg_v_bp  input  CNT_W each  requested vertical timing.
REQ-011 cfg_hs_pol, cfg_vs_pol  input  1 each  requested sync active level.
REQ-012 cfg_busy  output  1  staged config pending, not yet applied.
REQ-013 cfg_err  output  1  one-cycle pulse: request rejected.
REQ-014 hs, vs  output  1 each  horizontal/vertical sync.
REQ-015 de  output  1  active video.
REQ-016 fs  output  1  one-cycle frame-start pulse.
REQ-017 active_x, active_y  output  CNT_W each  pixel coordinate during de, else 0.

Function
REQ-018 Line order SHALL be active, FP, sync, BP; h_cnt counts 0..H_TOTAL-1, H_TOTAL = sum of the four live h fields (CNT_W+2-bit arithmetic, truncation forbidden).
REQ-019 v_cnt SHALL increment when h_cnt wraps, counting 0..V_TOTAL-1 in the same order, then wrap to 0.
REQ-020 All outputs SHALL be registered, reflecting counter state of the previous cycle (latency 1).
REQ-021 de SHALL be 1 iff h_cnt<H_ACT and v_cnt<V_ACT; active_x=h_cnt, active_y=v_cnt while de, else 0.
REQ-022 hs SHALL equal hs_pol for h_cnt in [H_ACT+H_FP, H_ACT+H_FP+H_SYNC-1], else ~hs_pol.
REQ-023 vs SHALL equal vs_pol for all cycles of lines v_cnt in [V_ACT+V_FP, V_ACT+V_FP+V_SYNC-1], else ~vs_pol.
REQ-024 fs SHALL pulse for the cycle reflecting counters (0,0).
REQ-025 cfg_update SHALL be rejected with cfg_err if any field is 0; otherwise fields are copied to staging and cfg_busy set.
REQ-026 Staged config SHALL become live on the cycle counters wrap from (H_TOTAL-1,V_TOTAL-1) to (0,0); cfg_busy clears that cycle.
REQ-027 cfg_update coincident with the wrap cycle SHALL be staged and applied at the following wrap; the wrap applies the previously staged set.
REQ-028 A second valid cfg_update while busy SHALL overwrite staging; a rejected one SHALL leave staging unchanged.
REQ-029 en=0 SHALL hold counters at (0,0), drive de=0, fs=0, x=y=0, hs=~hs_pol, vs=~vs_pol, and apply any staged config immediately.
REQ-030 On en 0->1 counting SHALL start from (0,0) that cycle; fs asserts the next cycle.

Reset
REQ-031 rst_n=0 at a clk edge SHALL clear counters, staging, cfg_busy, cfg_err, de, fs, active_x, active_y and load all *_DEF values as live config.
REQ-032 During reset hs=~HS_POL_DEF, vs=~VS_POL_DEF; reset mid-frame or with cfg_busy set discards the pending config.

Configuration
REQ-033 Macro VTG_LINE_IRQ_EN defined: adds input cfg_irq_line (CNT_W) and output line_irq, a one-cycle registered pulse reflecting h_cnt=0 and v_cnt=cfg_irq_line; reset value 0; no pulse if cfg_irq_line>=V_TOTAL.
REQ-034 Macro undefined: cfg_irq_line and line_irq ports and logic SHALL not exist; all other behaviour identical.

Verification
REQ-035 Reset release, en=1, defaults -> fs period 533280 cycles; de high 800 cycles per line on 480 lines; hs low 128 cycles starting 840 cycles after de rise.
REQ-036 cfg H=4/1/2/1, V=3/1/1/1, pols 1/1, mid-frame -> cfg_busy until frame wrap; then fs period 48, de 4 of every 8 cycles on 3 lines, hs high 2 cycles, vs high 8 cycles.
REQ-037 cfg_update with cfg_v_sync=0 -> cfg_err one cycle, cfg_busy unchanged, timing unaffected.
REQ-038 cfg_update on exact wrap cycle -> old config runs one more full frame, new config from next fs.
REQ-039 rst_n low for 1 cycle mid-line with cfg_busy=1 -> outputs at reset values, busy cleared, default 800x480 timing resumes.
REQ-040 VTG_LINE_IRQ_EN, cfg_irq_line=479, defaults -> line_irq once per frame, at the cycle reflecting (0,479) with active_y=479.
